// File: rtl/serial_ripple_subtractor_if.sv
// Start/done operand bus for the bit-serial subtractor.
// master drives start/a/b/bin; slave returns diff/bout/busy/done.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Ports: clk, rst (async high), bus (slave: start/a/b/bin in, diff/bout/busy/done out).
module serial_ripple_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic                  clk,
  input logic                  rst,
  serial_ripple_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_q;
  logic             br;
  logic             bout_q;
  logic [CNT_W-1:0] cnt;

  logic ai;
  logic bi;
  logic di;
  logic br_nxt;
  logic last;
  logic accept;

  assign ai     = sa[0];
  assign bi     = sb[0];
  assign di     = ai ^ bi ^ br;
  assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = bus.start && (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB and walk down, so after
  // WIDTH shifts the first (LSB) bit sits at res[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      br  <= bus.bin;
      res <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_nxt;
      res <= {di, res[WIDTH-1:1]};
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        diff_q <= {di, res[WIDTH-1:1]};
        bout_q <= br_nxt;
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: vector table,
// random ops vs arithmetic model, handshake corner cases.
module tb_serial_ripple_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;
  logic [W-1:0] prev;

  serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

  serial_ripple_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bi
  );
    int r;
    r = int'(a) - int'(b) - int'(bi);
    if (r < 0) r += (1 << (W + 1));
    return r[W:0];
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One start pulse; optional stray start + operand
  // change at RUN cycle tw (0 = none).
  task automatic run_op(
    input string        nm,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         bi,
    input logic [W-1:0] ed,
    input logic         eb,
    input int           tw
  );
    int lat;
    int nb;
    bit got;
    lat = 0;
    nb  = 0;
    got = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 4 * W && !got; k++) begin
      if (k > 1) @(negedge clk);
      if (tw != 0 && k == tw) begin
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd2;
        bus.bin   = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 1) chk({nm, "_hold"}, 32'(bus.diff), 32'(prev));
      if (bus.busy) nb++;
      if (bus.done) begin
        got = 1;
        lat = k;
        chk({nm, "_excl"}, 32'(bus.busy), 0);
      end
    end
    bus.start = 1'b0;
    chk({nm, "_lat"}, 32'(lat), W + 1);
    chk({nm, "_busy"}, 32'(nb), W);
    chk({nm, "_diff"}, 32'(bus.diff), 32'(ed));
    chk({nm, "_bout"}, 32'(bus.bout), 32'(eb));
    prev = bus.diff;
  endtask

  task automatic quiet(input string nm, input int n);
    int nd;
    nd = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk({nm, "_quiet"}, 32'(nd), 0);
  endtask

  vec_t tbl[8];
  logic [W-1:0] pa[5];
  logic [W-1:0] pb[5];
  logic         pc[5];

  initial begin
    logic [W:0] m;
    int t;
    int lastt;
    int nd;
    int idx;

    nchk = 0;
    nerr = 0;
    prev = '0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    tbl[0] = '{8'd10,  8'd3,   1'b0, 8'd7,   1'b0};
    tbl[1] = '{8'd3,   8'd10,  1'b0, 8'd249, 1'b1};
    tbl[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
    tbl[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1};
    tbl[4] = '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0};
    tbl[5] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    tbl[6] = '{8'd128, 8'd1,   1'b1, 8'd126, 1'b0};
    tbl[7] = '{8'd1,   8'd2,   1'b0, 8'd255, 1'b1};

    rst = 1'b1;
    #12;
    chk("rst_diff", 32'(bus.diff), 0);
    chk("rst_bout", 32'(bus.bout), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
             tbl[i].bin, tbl[i].ed, tbl[i].eb, 0);
    end

    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      m  = model(ra, rb, rc);
      run_op($sformatf("rnd%0d", i), ra, rb, rc,
             m[W-1:0], m[W], 0);
    end

    // stray start and operand change mid-run
    run_op("ign", 8'd50, 8'd20, 1'b0, 8'd30, 1'b0, 4);
    quiet("ign", 2 * W);

    // start held high: back-to-back operations
    for (int i = 0; i < 5; i++) begin
      pa[i] = W'($urandom);
      pb[i] = W'($urandom);
      pc[i] = 1'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = pa[0];
    bus.b     = pb[0];
    bus.bin   = pc[0];
    t = 0;
    lastt = 0;
    nd = 0;
    idx = 0;
    while (nd < 5 && t < 80) begin
      @(negedge clk);
      t++;
      if (bus.done) begin
        m = model(pa[idx], pb[idx], pc[idx]);
        chk("b2b_diff", 32'(bus.diff), 32'(m[W-1:0]));
        chk("b2b_bout", 32'(bus.bout), 32'(m[W]));
        chk("b2b_gap", 32'(t - lastt), W + 1);
        lastt = t;
        nd++;
        idx++;
        prev = bus.diff;
        if (idx < 5) begin
          bus.a   = pa[idx];
          bus.b   = pb[idx];
          bus.bin = pc[idx];
        end else begin
          bus.start = 1'b0;
        end
      end else if (bus.diff !== prev) begin
        chk("b2b_stable", 32'(bus.diff), 32'(prev));
      end
    end
    bus.start = 1'b0;
    chk("b2b_count", 32'(nd), 5);
    quiet("b2b", W);

    // async reset mid-run
    run_op("pre", 8'd200, 8'd17, 1'b0, 8'd183, 1'b0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'd90;
    bus.b     = 8'd9;
    bus.bin   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_diff", 32'(bus.diff), 0);
    chk("arst_bout", 32'(bus.bout), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_done", 32'(bus.done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev = '0;
    quiet("arst", 2 * W);
    chk("arst_hold", 32'(bus.diff), 0);
    run_op("post", 8'd90, 8'd9, 1'b1, 8'd80, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Multi-cycle, bit-serial subtractor. Computes a - b - bin one bit per clock, LSB first, with a registered ripple borrow.
- Companion to the combinational 8-bit adder in the arithmetic library. Provides the inverse operation with a start/done handshake.
- Intended for area-constrained datapaths where one full-width subtract every WIDTH+1 cycles is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      asynchronous, active-high reset
- start  input   1      request; sampled only when busy=0
- a      input   WIDTH  minuend; captured on accepted start
- b      input   WIDTH  subtrahend; captured on accepted start
- bin    input   1      borrow-in; captured on accepted start
- diff   output  WIDTH  difference (a - b - bin) mod 2^WIDTH
- bout   output  1      borrow-out; 1 iff a < b + bin (unsigned)
- busy   output  1      high while computing
- done   output  1      one-cycle pulse; diff/bout valid from this cycle

Behaviour:
- Reset: asynchronous, active-high. All of the following go to 0 immediately and hold while rst=1:
  - state -> IDLE
  - diff, bout, busy, done
  - internal shift registers, borrow flop, bit counter
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0.
  - start=1 at an edge: latch a, b, bin into shift regs/borrow flop; clear counter; go to RUN.
- RUN: busy=1. Each edge processes bit i = counter:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - shift d_i into result reg MSB-ward, LSB first; increment counter.
  - After WIDTH edges in RUN, the last edge loads diff and bout (= final br) and moves to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (go to RUN); otherwise go to IDLE.
- Latency: start sampled at edge E0 -> done high during the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the start edge. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- diff/bout are only updated at the RUN->DONE edge. They hold until the next completion or reset, so intermediate bits never appear on diff.
- start while busy=1 is ignored: no restart, no latch of a/b/bin. Operand changes during RUN have no effect.
- start held high continuously gives back-to-back operations, each taking the next a/b/bin presented in IDLE/DONE.
- Width rule: {bout, diff} equals (a - b - bin) mod 2^(WIDTH+1), unsigned.
- Reset asserted mid-RUN aborts the operation: outputs go to 0, no done pulse. The first start after reset release behaves normally.
- done and busy are never high in the same cycle.

Test Plan:
- a=10, b=3, bin=0, start pulse -> busy high 8 cycles; done pulse at cycle 9; diff=7, bout=0.
- a=3, b=10, bin=0 -> diff=249 (0xF9), bout=1. Also a=0, b=0, bin=1 -> diff=255, bout=1.
- a=255, b=255, bin=1 -> diff=255, bout=1. a=255, b=0, bin=0 -> diff=255, bout=0. a=0, b=0, bin=0 -> diff=0, bout=0.
- Start a=50, b=20, then pulse start with a=1, b=2 and change operands at cycle 4 of RUN -> ignored; result diff=30, bout=0 at the expected cycle. No second done pulse.
- start held high with a sequence of operand pairs -> done every 9 cycles; each diff/bout matches its own operands; diff stable between done pulses.
- Assert rst at cycle 5 of RUN (asynchronously, mid-cycle) -> diff, bout, busy, done go to 0 immediately; no done pulse. A new start after release yields the correct result.
